ucode_loop_ctrl: RTL and testbench
==================================

Name: ucode_loop_ctrl

Overview:
- Parametrised hardware-loop and offset controller for the HD accelerator microcode sequencer.
- Generalises the fixed three-level LOOP_SETUP0/1/2 scheme to NUM_LOOPS nesting levels with configurable iteration and address widths.
- Adds a wrapping offset register driven by the CLR/INC/DEC_OFFSET opcodes.
- Sits between the decoder and the program counter: it watches retired instruction addresses and issues zero-overhead backward jumps.

Parameters:
- NUM_LOOPS, 3, number of nesting levels. Level 0 is innermost.
- ITER_WIDTH, 10, width of the iteration count operand.
- ADDR_WIDTH, 10, microcode address width.
- OFFSET_WIDTH, 6, width of the offset register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous clear of all loop levels; offset is kept
- setup_valid_i  in  1  LOOP_SETUPn retires this cycle
- setup_level_i  in  max(1,$clog2(NUM_LOOPS))  target level n
- setup_iter_i  in  ITER_WIDTH  iteration count
- setup_end_addr_i  in  ADDR_WIDTH  inclusive loop end address
- setup_pc_i  in  ADDR_WIDTH  address of the setup instruction
- retire_valid_i  in  1  an instruction at retire_pc_i completes this cycle
- retire_pc_i  in  ADDR_WIDTH  address of the retiring instruction
- offset_op_i  in  2  00 none, 01 clear, 10 increment, 11 decrement
- jump_o  out  1  PC must load jump_target_o
- jump_target_o  out  ADDR_WIDTH  loop start address
- loop_active_o  out  NUM_LOOPS  per-level active flags
- offset_o  out  OFFSET_WIDTH  current offset
- err_o  out  1  registered one-cycle error pulse

Behaviour:
- **Reset:** all levels inactive; counters, start and end addresses = 0; offset_o = 0; err_o = 0; jump_o = 0; jump_target_o = 0.
- **Per-level state:** active, start = setup_pc_i+1 (modulo 2^ADDR_WIDTH), end, remaining count.
- **Setup:** setup_valid_i with iter ≥ 1 and level < NUM_LOOPS loads the level on the next edge and sets active. An already-active level is overwritten.
  - iter = 0: level is not loaded (left unchanged); err_o pulses the next cycle.
  - Level ≥ NUM_LOOPS (non-power-of-two NUM_LOOPS): setup is ignored; err_o pulses the next cycle.
- **Loop evaluation:** combinational, same cycle as retire_valid_i. Scan levels 0 → NUM_LOOPS-1 and consider only active levels with end == retire_pc_i.
  - Matching level with remaining == 1: cleared on the next edge; scanning continues outward.
  - First matching level with remaining > 1: jump_o = 1, jump_target_o = its start; remaining decrements on the next edge. Scanning stops; outer levels are untouched.
  - No qualifying level: jump_o = 0 and jump_target_o = 0.
- **Jump latency:** zero cycles; the PC uses jump_o in the same cycle.
- **Simultaneous setup and retire:** loop evaluation uses pre-edge state. If the setup targets a level that the evaluation also updates, the setup write wins.
- **Flush:** flush_i clears every active flag on the next edge and forces jump_o = 0 in the same cycle. Flush has priority over setup and retire.
- **Offset register:** clear → 0; increment/decrement wrap modulo 2^OFFSET_WIDTH. Updated on the next edge, independent of the loop logic.
- **Errors:** err_o is registered and pulses one cycle per erroneous setup; no other state changes.
- **Reset mid-loop:** asynchronously returns every output to its reset value within the same cycle.

Test Plan:
- **Single loop:** setup level 0, iter=3, end=0x012, pc=0x010; retire 0x011, 0x012 three times → jump_o=1 with target 0x011 on the first two retires of 0x012; third retire gives jump_o=0 and loop_active_o[0]=0.
- **Shared end address:** level 1 (iter 2, end 0x020, pc 0x010) and level 0 (iter 1, end 0x020, pc 0x015); retire 0x020 → level 0 cleared, jump to 0x011, level 1 remaining = 1.
- **Setup plus retire:** setup level 0 iter 5 while level 0 retires its end with remaining 2 → jump_o=1 this cycle; next cycle remaining = 5 (setup wins).
- **Error handling:** setup iter=0 → err_o high exactly one cycle, loop_active_o unchanged. With NUM_LOOPS=3, setup level 3 → err_o pulse.
- **Offset wrap:** offset 0, decrement → 63; increment → 0; increment ×5 then clear → 0.
- **Flush and reset:** flush_i asserted coincident with a qualifying retire → jump_o=0 that cycle and loop_active_o = 0 after the edge. Asserting rst_i mid-loop immediately clears loop_active_o and offset_o.

Source files
------------

// File: rtl/ucode_loop_ctrl.sv
// Hardware-loop and offset controller: nested zero-overhead loops driven by retired PCs,
// plus a wrapping offset register for the microcode sequencer.
module ucode_loop_ctrl #(
  parameter int NUM_LOOPS    = 3,
  parameter int ITER_WIDTH   = 10,
  parameter int ADDR_WIDTH   = 10,
  parameter int OFFSET_WIDTH = 6,
  localparam int LVL_W = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    setup_valid_i,
  input  logic [LVL_W-1:0]        setup_level_i,
  input  logic [ITER_WIDTH-1:0]   setup_iter_i,
  input  logic [ADDR_WIDTH-1:0]   setup_end_addr_i,
  input  logic [ADDR_WIDTH-1:0]   setup_pc_i,
  input  logic                    retire_valid_i,
  input  logic [ADDR_WIDTH-1:0]   retire_pc_i,
  input  logic [1:0]              offset_op_i,
  output logic                    jump_o,
  output logic [ADDR_WIDTH-1:0]   jump_target_o,
  output logic [NUM_LOOPS-1:0]    loop_active_o,
  output logic [OFFSET_WIDTH-1:0] offset_o,
  output logic                    err_o
);

  localparam logic [LVL_W:0] NUM_LOOPS_L = (LVL_W + 1)'(NUM_LOOPS);

  logic [NUM_LOOPS-1:0]  active_r;
  logic [ADDR_WIDTH-1:0] start_r     [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0] end_r       [NUM_LOOPS];
  logic [ITER_WIDTH-1:0] remaining_r [NUM_LOOPS];
  logic [OFFSET_WIDTH-1:0] offset_r;
  logic                  err_r;

  logic                  jump_s;
  logic [ADDR_WIDTH-1:0] target_s;
  logic [NUM_LOOPS-1:0]  clear_s;
  logic [NUM_LOOPS-1:0]  dec_s;
  logic                  found_s;
  logic                  level_ok_s;
  logic                  setup_ok_s;
  logic                  setup_err_s;

  // Setup qualification: a zero count or an out-of-range level is rejected and flagged.
  always_comb begin
    level_ok_s  = ({1'b0, setup_level_i} < NUM_LOOPS_L);
    setup_ok_s  = setup_valid_i && (setup_iter_i != {ITER_WIDTH{1'b0}}) && level_ok_s;
    setup_err_s = setup_valid_i && !setup_ok_s;
  end

  // Loop evaluation: innermost first; exhausted levels fall through, the first live one jumps.
  always_comb begin
    jump_s   = 1'b0;
    target_s = {ADDR_WIDTH{1'b0}};
    clear_s  = {NUM_LOOPS{1'b0}};
    dec_s    = {NUM_LOOPS{1'b0}};
    found_s  = 1'b0;
    if (retire_valid_i && !flush_i) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        if (!found_s && active_r[i] && (end_r[i] == retire_pc_i)) begin
          if (remaining_r[i] == ITER_WIDTH'(1)) begin
            clear_s[i] = 1'b1;
          end else begin
            dec_s[i] = 1'b1;
            jump_s   = 1'b1;
            target_s = start_r[i];
            found_s  = 1'b1;
          end
        end else begin
          clear_s[i] = clear_s[i];
        end
      end
    end else begin
      jump_s = 1'b0;
    end
  end

  // Per-level state: flush beats setup, and setup beats the evaluation update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_r <= {NUM_LOOPS{1'b0}};
      for (int i = 0; i < NUM_LOOPS; i++) begin
        start_r[i]     <= {ADDR_WIDTH{1'b0}};
        end_r[i]       <= {ADDR_WIDTH{1'b0}};
        remaining_r[i] <= {ITER_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        if (flush_i) begin
          active_r[i] <= 1'b0;
        end else if (setup_ok_s && (setup_level_i == LVL_W'(i))) begin
          active_r[i]    <= 1'b1;
          start_r[i]     <= setup_pc_i + ADDR_WIDTH'(1);
          end_r[i]       <= setup_end_addr_i;
          remaining_r[i] <= setup_iter_i;
        end else if (clear_s[i]) begin
          active_r[i]    <= 1'b0;
          remaining_r[i] <= {ITER_WIDTH{1'b0}};
        end else if (dec_s[i]) begin
          remaining_r[i] <= remaining_r[i] - ITER_WIDTH'(1);
        end
      end
    end
  end

  // Offset register and error pulse, independent of the loop levels.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      offset_r <= {OFFSET_WIDTH{1'b0}};
      err_r    <= 1'b0;
    end else begin
      err_r <= setup_err_s;
      case (offset_op_i)
        2'b01:   offset_r <= {OFFSET_WIDTH{1'b0}};
        2'b10:   offset_r <= offset_r + OFFSET_WIDTH'(1);
        2'b11:   offset_r <= offset_r - OFFSET_WIDTH'(1);
        default: offset_r <= offset_r;
      endcase
    end
  end

  // The jump path stays combinational so the PC can redirect in the retire cycle.
  assign jump_o        = jump_s;
  assign jump_target_o = target_s;
  assign loop_active_o = active_r;
  assign offset_o      = offset_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_ucode_loop_ctrl.sv
// Directed bench for ucode_loop_ctrl: per-cycle expected outputs are queued with the
// stimulus and compared at the falling edge of the same cycle.
module tb_ucode_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       setup_valid;
  logic [1:0] setup_level;
  logic [9:0] setup_iter;
  logic [9:0] setup_end_addr;
  logic [9:0] setup_pc;
  logic       retire_valid;
  logic [9:0] retire_pc;
  logic [1:0] offset_op;
  logic       jump;
  logic [9:0] jump_target;
  logic [2:0] loop_active;
  logic [5:0] offset;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       jump;
    logic [9:0] target;
    logic [2:0] active;
    logic [5:0] offset;
    logic       err;
  } exp_t;

  exp_t sb[$];

  ucode_loop_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .setup_valid_i    (setup_valid),
    .setup_level_i    (setup_level),
    .setup_iter_i     (setup_iter),
    .setup_end_addr_i (setup_end_addr),
    .setup_pc_i       (setup_pc),
    .retire_valid_i   (retire_valid),
    .retire_pc_i      (retire_pc),
    .offset_op_i      (offset_op),
    .jump_o           (jump),
    .jump_target_o    (jump_target),
    .loop_active_o    (loop_active),
    .offset_o         (offset),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    flush        = 1'b0;
    setup_valid  = 1'b0;
    setup_level  = 2'd0;
    setup_iter   = 10'd0;
    setup_end_addr = 10'd0;
    setup_pc     = 10'd0;
    retire_valid = 1'b0;
    retire_pc    = 10'd0;
    offset_op    = 2'b00;
  endtask

  task automatic do_setup(input logic [1:0] lvl, input logic [9:0] it,
                          input logic [9:0] ea, input logic [9:0] pc);
    setup_valid    = 1'b1;
    setup_level    = lvl;
    setup_iter     = it;
    setup_end_addr = ea;
    setup_pc       = pc;
  endtask

  task automatic do_retire(input logic [9:0] pc);
    retire_valid = 1'b1;
    retire_pc    = pc;
  endtask

  task automatic expect_now(input string tag, input logic j, input logic [9:0] t,
                            input logic [2:0] a, input logic [5:0] o, input logic e);
    exp_t x;
    x.tag = tag; x.jump = j; x.target = t; x.active = a; x.offset = o; x.err = e;
    sb.push_back(x);
  endtask

  // Sample mid-cycle, then advance one clock and return inputs to idle.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".jump"},   {31'd0, jump},        {31'd0, x.jump});
      chk({x.tag, ".target"}, {22'd0, jump_target}, {22'd0, x.target});
      chk({x.tag, ".active"}, {29'd0, loop_active}, {29'd0, x.active});
      chk({x.tag, ".offset"}, {26'd0, offset},      {26'd0, x.offset});
      chk({x.tag, ".err"},    {31'd0, err},         {31'd0, x.err});
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    expect_now("reset", 1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();
    rst = 1'b0;

    // Single loop at level 0: three passes over 0x011..0x012.
    do_setup(2'd0, 10'd3, 10'h012, 10'h010);
    expect_now("s1_setup", 1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();
    do_retire(10'h011);
    expect_now("s1_body1", 1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();
    do_retire(10'h012);
    expect_now("s1_end1",  1'b1, 10'h011, 3'b001, 6'd0, 1'b0); tick();
    do_retire(10'h011);
    expect_now("s1_body2", 1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();
    do_retire(10'h012);
    expect_now("s1_end2",  1'b1, 10'h011, 3'b001, 6'd0, 1'b0); tick();
    do_retire(10'h012);
    expect_now("s1_end3",  1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();
    expect_now("s1_done",  1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();

    // Shared end address: inner level exhausts, outer level takes the jump.
    do_setup(2'd1, 10'd2, 10'h020, 10'h010);
    expect_now("sh_setup1", 1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();
    do_setup(2'd0, 10'd1, 10'h020, 10'h015);
    expect_now("sh_setup0", 1'b0, 10'h000, 3'b010, 6'd0, 1'b0); tick();
    do_retire(10'h020);
    expect_now("sh_end1",   1'b1, 10'h011, 3'b011, 6'd0, 1'b0); tick();
    do_retire(10'h020);
    expect_now("sh_end2",   1'b0, 10'h000, 3'b010, 6'd0, 1'b0); tick();
    expect_now("sh_done",   1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();

    // Setup coincident with a jumping retire: the reload to 5 must win over the decrement.
    do_setup(2'd0, 10'd2, 10'h030, 10'h02E);
    expect_now("sr_setup", 1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();
    do_setup(2'd0, 10'd5, 10'h030, 10'h02E);
    do_retire(10'h030);
    expect_now("sr_both",  1'b1, 10'h02F, 3'b001, 6'd0, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      do_retire(10'h030);
      expect_now($sformatf("sr_pass%0d", k), 1'b1, 10'h02F, 3'b001, 6'd0, 1'b0); tick();
    end
    do_retire(10'h030);
    expect_now("sr_last",  1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();
    expect_now("sr_done",  1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();

    // Errors: zero count and out-of-range level leave loop state alone.
    do_setup(2'd0, 10'd3, 10'h040, 10'h03F);
    expect_now("er_setup",  1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();
    do_setup(2'd0, 10'd0, 10'h050, 10'h050);
    expect_now("er_iter0",  1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();
    expect_now("er_pulse0", 1'b0, 10'h000, 3'b001, 6'd0, 1'b1); tick();
    expect_now("er_quiet0", 1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();
    do_retire(10'h040);
    expect_now("er_kept",   1'b1, 10'h040, 3'b001, 6'd0, 1'b0); tick();
    do_setup(2'd3, 10'd2, 10'h060, 10'h05F);
    expect_now("er_lvl3",   1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();
    expect_now("er_pulse3", 1'b0, 10'h000, 3'b001, 6'd0, 1'b1); tick();
    expect_now("er_quiet3", 1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();

    // Flush coincident with a qualifying retire.
    flush = 1'b1;
    do_retire(10'h040);
    expect_now("fl_cycle", 1'b0, 10'h000, 3'b001, 6'd0, 1'b0); tick();
    expect_now("fl_after", 1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();

    // Offset wrap in both directions, then clear.
    offset_op = 2'b11;
    expect_now("of_dec",   1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();
    offset_op = 2'b10;
    expect_now("of_wrap",  1'b0, 10'h000, 3'b000, 6'd63, 1'b0); tick();
    for (int k = 0; k < 5; k++) begin
      offset_op = 2'b10;
      expect_now($sformatf("of_inc%0d", k), 1'b0, 10'h000, 3'b000, 6'(k), 1'b0); tick();
    end
    offset_op = 2'b01;
    expect_now("of_clr",   1'b0, 10'h000, 3'b000, 6'd5, 1'b0); tick();
    flush = 1'b1;
    offset_op = 2'b10;
    expect_now("of_cleared", 1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();
    expect_now("of_flushkeep", 1'b0, 10'h000, 3'b000, 6'd1, 1'b0); tick();

    // Reset mid-loop while a qualifying retire is presented.
    do_setup(2'd0, 10'd3, 10'h070, 10'h06F);
    expect_now("rs_setup", 1'b0, 10'h000, 3'b000, 6'd1, 1'b0); tick();
    expect_now("rs_live",  1'b0, 10'h000, 3'b001, 6'd1, 1'b0); tick();
    rst = 1'b1;
    do_retire(10'h070);
    expect_now("rs_mid",   1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();
    rst = 1'b0;
    do_retire(10'h070);
    expect_now("rs_after", 1'b0, 10'h000, 3'b000, 6'd0, 1'b0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
